stream_offload_mux: RTL
=======================

STREAM_OFFLOAD_MUX -- requirements
Module: stream_offload_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning tdata width in bits; tkeep is DATA_WIDTH/8.
REQ-002 SHALL have parameter ID_WIDTH, default 6, meaning tid width.
REQ-003 SHALL have parameter MAX_OUTST, default 4, meaning the maximum number of offload packets in flight (1..255).
REQ-004 SHALL have ports: aclk in 1 clock; areset in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: s_axis_host_{tvalid,tready,tdata,tkeep,tid,tlast}, an AXI4-Stream slave carrying host ingress packets.
REQ-006 SHALL have ports: m_axis_host_{tvalid,tready,tdata,tkeep,tid,tlast}, an AXI4-Stream master carrying host egress packets.
REQ-007 SHALL have ports: m_axis_off_{...}, a master to the offload engine, and s_axis_off_{...}, a slave returning from the offload engine, with the same field set.
REQ-008 SHALL have ports: mode in 2: 00 auto, 01 force bypass, 10 force offload, 11 drop-to-bypass-when-full.
REQ-009 SHALL have ports: ctrl_val in 64 and thresh in 64, which are the auto-mode decision operands.
REQ-010 SHALL have port busy out 1, which is high when outstanding>0 or the FSM is not IDLE.

Function
REQ-011 SHALL use an ingress FSM with states IDLE, BYP and OFF, and SHALL make the route decision only in IDLE on the first beat of a packet.
REQ-012 SHALL decide the route in auto mode as offload iff ctrl_val > thresh (unsigned), sampled on the first-beat cycle; mode 01 SHALL always select bypass and mode 10 SHALL always select offload.
REQ-013 SHALL, in mode 11, apply the auto decision, but an offload decision made while outstanding==MAX_OUTST SHALL become bypass.
REQ-014 SHALL latch the route for the whole packet; changes to mode, ctrl_val or thresh mid-packet SHALL have no effect until after tlast.
REQ-015 SHALL stall a pending offload start (s_axis_host_tready=0) while outstanding==MAX_OUTST, except as covered by REQ-013.
REQ-016 SHALL stall a pending bypass start while outstanding>0, so that egress order equals ingress order.
REQ-017 SHALL, in BYP, connect s_axis_host combinationally to m_axis_host with zero latency: tready=m_axis_host_tready and all fields passed through; the FSM SHALL return to IDLE on a tlast handshake.
REQ-018 SHALL, in OFF, connect s_axis_host combinationally to m_axis_off; the FSM SHALL return to IDLE on a tlast handshake.
REQ-019 SHALL increment outstanding on the first-beat handshake of an offload packet, and SHALL decrement it on a tlast handshake on s_axis_off.
REQ-020 SHALL, when an increment and a decrement occur in the same cycle, leave outstanding unchanged.
REQ-021 SHALL forward s_axis_off to m_axis_host whenever the FSM is not in BYP; s_axis_off_tready SHALL be 0 while in BYP.
REQ-022 SHALL never interleave beats of different packets on m_axis_host.
REQ-023 SHALL hold off the IDLE->BYP transition while a returned offload packet is mid-transfer on egress; the mid-transfer condition is tracked by a 1-bit egress-in-packet flag.
REQ-024 SHALL never modify tdata, tkeep, tid or tlast on any path.
REQ-025 SHALL hold outstanding at 0 on a decrement while outstanding==0, which is engine misbehaviour.
REQ-026 SHALL reassert err_underflow (out, 1, sticky until reset) in that case.

Reset
REQ-027 SHALL, while areset is low, force: FSM=IDLE; outstanding=0; egress-in-packet flag=0; err_underflow=0; and all tvalid and tready outputs to 0.
REQ-028 SHALL, when reset is asserted mid-packet, abandon the packet with no recovery beat; the first beat accepted after deassertion SHALL be treated as a packet start.
REQ-029 SHALL accept no handshake in the first cycle after deassertion.

Configuration
REQ-030 SHALL, when macro STREAM_OFFLOAD_MUX_STATS_EN is defined, add outputs byp_pkts out 32 and off_pkts out 32, which count tlast handshakes per route at ingress; both SHALL reset to 0 and wrap at 2^32-1 to 0.
REQ-031 SHALL, when STREAM_OFFLOAD_MUX_STATS_EN is undefined, omit those ports and their counters entirely, with function otherwise identical.

Verification
REQ-032 SHALL cover: mode=00, ctrl_val=20000, thresh=10000, 3-beat packet -> 3 beats on m_axis_off, outstanding=1; engine returns 3 beats -> egress receives them and outstanding=0.
REQ-033 SHALL cover: mode=00, ctrl_val=5 -> packet appears on m_axis_host in the same cycle as input, and m_axis_off_tvalid stays 0.
REQ-034 SHALL cover: offload packet A, then bypass packet B, with the engine delaying 50 cycles -> B is stalled until A's tlast leaves egress, and egress order is A, B.
REQ-035 SHALL cover: MAX_OUTST=2, mode=10, 3 packets with the engine stalled -> the third packet's first beat waits with tready=0; mode=11 -> the third packet bypasses only after outstanding==0.
REQ-036 SHALL cover: ctrl_val toggled below thresh on beat 2 of an offload packet -> the remaining beats still go to m_axis_off.
REQ-037 SHALL cover: areset pulsed low for 1 cycle mid-offload-packet -> all valids drop asynchronously, outstanding=0, and the next packet is routed fresh; with STATS_EN defined, off_pkts and byp_pkts read 0.

Source files
------------

// File: rtl/stream_offload_mux.sv
// Routes host AXI4-Stream packets either straight to host egress (bypass) or through an
// offload engine, keeping egress order equal to ingress order. STREAM_OFFLOAD_MUX_STATS_EN adds packet counters.
module stream_offload_mux #(
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 6,
   parameter int MAX_OUTST  = 4
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    s_axis_host_tvalid,
   output logic                    s_axis_host_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_host_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_host_tkeep,
   input  logic [ID_WIDTH-1:0]     s_axis_host_tid,
   input  logic                    s_axis_host_tlast,
   output logic                    m_axis_host_tvalid,
   input  logic                    m_axis_host_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_host_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_host_tkeep,
   output logic [ID_WIDTH-1:0]     m_axis_host_tid,
   output logic                    m_axis_host_tlast,
   output logic                    m_axis_off_tvalid,
   input  logic                    m_axis_off_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_off_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_off_tkeep,
   output logic [ID_WIDTH-1:0]     m_axis_off_tid,
   output logic                    m_axis_off_tlast,
   input  logic                    s_axis_off_tvalid,
   output logic                    s_axis_off_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_off_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_off_tkeep,
   input  logic [ID_WIDTH-1:0]     s_axis_off_tid,
   input  logic                    s_axis_off_tlast,
   input  logic [1:0]              mode,
   input  logic [63:0]             ctrl_val,
   input  logic [63:0]             thresh,
   output logic                    busy,
   output logic                    err_underflow
`ifdef STREAM_OFFLOAD_MUX_STATS_EN
   ,
   output logic [31:0]             byp_pkts,
   output logic [31:0]             off_pkts
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BYP  = 2'd1,
      ST_OFF  = 2'd2
   } state_e;

   localparam logic [7:0] MAX_C = 8'(MAX_OUTST);

   state_e      state_q, state_d;
   logic [7:0]  outst_q, outst_d;
   logic        eg_pkt_q, eg_pkt_d;
   logic        err_q, err_d;
   logic        rdy_q;
   logic        pend_vld_q, pend_vld_d;
   logic        pend_off_q, pend_off_d;

   logic        auto_off_s;
   logic        full_s;
   logic        dec_off_s;
   logic        route_off_s;
   logic        start_off_ok_s;
   logic        start_byp_ok_s;
   logic        byp_path_s;
   logic        off_path_s;
   logic        host_hs_s;
   logic        ret_hs_s;
   logic        inc_s;
   logic        dec_s;

   assign auto_off_s     = (ctrl_val > thresh);
   assign full_s         = (outst_q == MAX_C);
   assign start_off_ok_s = !full_s;
   assign start_byp_ok_s = (outst_q == 8'd0) && !eg_pkt_q;

   // Route decision from the live mode/operands; mode 11 diverts a full-engine offload to bypass.
   always_comb begin
      dec_off_s = 1'b0;
      case (mode)
         2'b00:   dec_off_s = auto_off_s;
         2'b01:   dec_off_s = 1'b0;
         2'b10:   dec_off_s = 1'b1;
         2'b11:   dec_off_s = auto_off_s && !full_s;
         default: dec_off_s = 1'b0;
      endcase
   end

   // A stalled first beat keeps the decision taken when it first appeared.
   assign route_off_s = pend_vld_q ? pend_off_q : dec_off_s;

   // State register.
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (host_hs_s && !s_axis_host_tlast) begin
               state_d = off_path_s ? ST_OFF : ST_BYP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BYP, ST_OFF: begin
            if (host_hs_s && s_axis_host_tlast) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: which ingress path is connected this cycle.
   always_comb begin
      byp_path_s = 1'b0;
      off_path_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (route_off_s) begin
               off_path_s = start_off_ok_s && rdy_q;
            end else begin
               byp_path_s = start_byp_ok_s && s_axis_host_tvalid && rdy_q;
            end
         end
         ST_BYP:  byp_path_s = rdy_q;
         ST_OFF:  off_path_s = rdy_q;
         default: begin
            byp_path_s = 1'b0;
            off_path_s = 1'b0;
         end
      endcase
   end

   assign s_axis_host_tready = byp_path_s ? m_axis_host_tready :
                               (off_path_s ? m_axis_off_tready : 1'b0);
   assign m_axis_off_tvalid  = off_path_s && s_axis_host_tvalid;
   assign m_axis_off_tdata   = s_axis_host_tdata;
   assign m_axis_off_tkeep   = s_axis_host_tkeep;
   assign m_axis_off_tid     = s_axis_host_tid;
   assign m_axis_off_tlast   = s_axis_host_tlast;

   assign m_axis_host_tvalid = byp_path_s ? s_axis_host_tvalid : (s_axis_off_tvalid && rdy_q);
   assign m_axis_host_tdata  = byp_path_s ? s_axis_host_tdata : s_axis_off_tdata;
   assign m_axis_host_tkeep  = byp_path_s ? s_axis_host_tkeep : s_axis_off_tkeep;
   assign m_axis_host_tid    = byp_path_s ? s_axis_host_tid   : s_axis_off_tid;
   assign m_axis_host_tlast  = byp_path_s ? s_axis_host_tlast : s_axis_off_tlast;
   assign s_axis_off_tready  = (!byp_path_s && rdy_q) ? m_axis_host_tready : 1'b0;

   assign host_hs_s = s_axis_host_tvalid && s_axis_host_tready;
   assign ret_hs_s  = s_axis_off_tvalid && s_axis_off_tready;
   assign inc_s     = (state_q == ST_IDLE) && off_path_s && host_hs_s;
   assign dec_s     = ret_hs_s && s_axis_off_tlast;

   assign busy          = (outst_q != 8'd0) || (state_q != ST_IDLE);
   assign err_underflow = err_q;

   // Outstanding counter, underflow flag, egress-in-packet flag and pending decision next-state.
   always_comb begin
      outst_d    = outst_q;
      err_d      = err_q;
      eg_pkt_d   = eg_pkt_q;
      pend_vld_d = pend_vld_q;
      pend_off_d = pend_off_q;
      if (inc_s && !dec_s) begin
         outst_d = outst_q + 8'd1;
      end else if (dec_s && !inc_s) begin
         if (outst_q == 8'd0) begin
            err_d = 1'b1;
         end else begin
            outst_d = outst_q - 8'd1;
         end
      end else begin
         outst_d = outst_q;
      end
      if (ret_hs_s) begin
         eg_pkt_d = !s_axis_off_tlast;
      end else begin
         eg_pkt_d = eg_pkt_q;
      end
      if (host_hs_s) begin
         pend_vld_d = 1'b0;
      end else if ((state_q == ST_IDLE) && s_axis_host_tvalid && !pend_vld_q) begin
         pend_vld_d = 1'b1;
         pend_off_d = dec_off_s;
      end else begin
         pend_vld_d = pend_vld_q;
      end
   end

   // Bookkeeping registers; rdy_q blocks all handshakes for one cycle after reset release.
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         outst_q    <= 8'd0;
         err_q      <= 1'b0;
         eg_pkt_q   <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_off_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         outst_q    <= outst_d;
         err_q      <= err_d;
         eg_pkt_q   <= eg_pkt_d;
         pend_vld_q <= pend_vld_d;
         pend_off_q <= pend_off_d;
         rdy_q      <= 1'b1;
      end
   end

`ifdef STREAM_OFFLOAD_MUX_STATS_EN
   logic [31:0] byp_cnt_q, byp_cnt_d;
   logic [31:0] off_cnt_q, off_cnt_d;

   // Ingress packet counters per route, wrapping naturally.
   always_comb begin
      byp_cnt_d = byp_cnt_q;
      off_cnt_d = off_cnt_q;
      if (host_hs_s && s_axis_host_tlast && byp_path_s) begin
         byp_cnt_d = byp_cnt_q + 32'd1;
      end else if (host_hs_s && s_axis_host_tlast && off_path_s) begin
         off_cnt_d = off_cnt_q + 32'd1;
      end else begin
         byp_cnt_d = byp_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         byp_cnt_q <= 32'd0;
         off_cnt_q <= 32'd0;
      end else begin
         byp_cnt_q <= byp_cnt_d;
         off_cnt_q <= off_cnt_d;
      end
   end

   assign byp_pkts = byp_cnt_q;
   assign off_pkts = off_cnt_q;
`endif

endmodule
